// File: rtl/spi_pkg.sv
// spi_pkg: shared word width, watchdog default and FSM state encoding for the SPI request arbiter.
package spi_pkg;
   localparam int SPI_DW      = 12;
   localparam int TIMEOUT_DEF = 1024;
   typedef enum logic [1:0] {IDLE, LAUNCH, XFER, DRAIN} state_e;
   function automatic int wrap_inc(int i, int n);
      return (i + 1) % n;
   endfunction
endpackage

// File: rtl/spi_req_arbiter_if.sv
// spi_req_arbiter_if: client request/ack bundle plus the link to the shared SPI master.
interface spi_req_arbiter_if #(
   parameter int NREQ = 4,
   parameter int DW   = spi_pkg::SPI_DW
);
   logic [NREQ-1:0]    req, ack, err, cs_n;
   logic [NREQ*DW-1:0] req_data;
   logic               busy, spi_start, spi_cs, spi_done;
   logic [DW-1:0]      spi_din;
   modport master (input req, req_data, spi_cs, spi_done,
                   output ack, err, busy, cs_n, spi_start, spi_din);
   modport slave  (output req, req_data, spi_cs, spi_done,
                   input ack, err, busy, cs_n, spi_start, spi_din);
endinterface

// File: rtl/spi_req_arbiter_rr_arbiter.sv
// spi_req_arbiter_rr_arbiter: combinational rotate-priority encoder, first request at or above ptr wins.
module spi_req_arbiter_rr_arbiter #(
   parameter int  NREQ = 4,
   localparam int IW   = $clog2(NREQ)
) (
   input  logic [NREQ-1:0] req,
   input  logic [IW-1:0]   ptr,
   output logic [IW-1:0]   gnt,
   output logic            valid
);
   logic [IW-1:0] idx;
   always_comb begin
      gnt   = '0;
      valid = 1'b0;
      idx   = '0;
      // scan downward so the lowest offset from ptr is the last (winning) assignment
      for (int i = NREQ - 1; i >= 0; i--) begin
         idx = IW'((int'(ptr) + i) % NREQ);
         if (req[idx]) begin
            gnt   = idx;
            valid = 1'b1;
         end
      end
   end
endmodule

// File: rtl/spi_req_arbiter.sv
// spi_req_arbiter: round-robin sharing of one SPI master between NREQ clients,
// with cs routing, launch handshake, done draining and a per-transfer watchdog.
module spi_req_arbiter import spi_pkg::*; #(
   parameter int NREQ    = 4,
   parameter int DW      = SPI_DW,
   parameter int TIMEOUT = TIMEOUT_DEF
) (
   input logic clk,
   input logic rst,
   spi_req_arbiter_if.master bus
);
   localparam int IW = $clog2(NREQ);
   localparam int WW = $clog2(TIMEOUT + 1);
   state_e          state_q, state_d;
   logic [IW-1:0]   gnt_q, gnt_d, ptr_q, ptr_d, arb_gnt;
   logic            arb_valid;
   logic [DW-1:0]   din_q, din_d, req_word;
   logic [NREQ-1:0] ack_q, ack_d, err_q, err_d;
   logic [WW-1:0]   wd_q, wd_d;

   spi_req_arbiter_rr_arbiter #(.NREQ(NREQ)) u_rr (
      .req(bus.req), .ptr(ptr_q), .gnt(arb_gnt), .valid(arb_valid)
   );

   always_comb begin
      req_word = '0;
      for (int i = 0; i < NREQ; i++)
         if (arb_gnt == IW'(i)) req_word = bus.req_data[i*DW +: DW];
   end

   always_comb begin
      state_d = state_q;
      gnt_d   = gnt_q;
      ptr_d   = ptr_q;
      din_d   = din_q;
      wd_d    = wd_q;
      ack_d   = '0;
      err_d   = '0;
      case (state_q)
         // the ack/err cycle is skipped so a client still holding req is not re-granted
         IDLE: if (arb_valid && bus.spi_cs && !bus.spi_done && !(|(ack_q | err_q))) begin
            state_d = LAUNCH;
            gnt_d   = arb_gnt;
            din_d   = req_word;
            wd_d    = '0;
         end
         LAUNCH: state_d = bus.spi_cs ? LAUNCH : XFER;
         XFER:   state_d = bus.spi_done ? DRAIN : XFER;
         DRAIN: if (!bus.spi_done) begin
            state_d        = IDLE;
            ack_d[gnt_q]   = 1'b1;
         end
         default: state_d = IDLE;
      endcase
      if (state_q != IDLE) begin
         wd_d = wd_q + 1'b1;
         // a transfer that completes on the last watchdog cycle is still acked
         if (state_d != IDLE && wd_q == WW'(TIMEOUT - 1)) begin
            state_d      = IDLE;
            err_d[gnt_q] = 1'b1;
         end
         ptr_d = (state_d == IDLE) ? IW'(wrap_inc(int'(gnt_q), NREQ)) : ptr_q;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         gnt_q   <= '0;
         ptr_q   <= '0;
         din_q   <= '0;
         wd_q    <= '0;
         ack_q   <= '0;
         err_q   <= '0;
      end else begin
         state_q <= state_d;
         gnt_q   <= gnt_d;
         ptr_q   <= ptr_d;
         din_q   <= din_d;
         wd_q    <= wd_d;
         ack_q   <= ack_d;
         err_q   <= err_d;
      end
   end

   assign bus.busy      = state_q != IDLE;
   assign bus.spi_start = state_q == LAUNCH;
   assign bus.spi_din   = din_q;
   assign bus.ack       = ack_q;
   assign bus.err       = err_q;
   assign bus.cs_n      = (state_q == IDLE) ? '1 : ~(NREQ'(!bus.spi_cs) << gnt_q);
endmodule

// File: tb/tb_spi_req_arbiter.sv
// tb_spi_req_arbiter: random clients and a behavioural SPI master stub, checked every cycle
// against a transaction-level model, plus directed scenarios with literal expectations.
module tb_spi_req_arbiter;
   import spi_pkg::*;
   localparam int N = 4, W = SPI_DW, TO = 100;
   logic clk = 1'b0, rst = 1'b1;
   always #5 clk = ~clk;

   spi_req_arbiter_if #(.NREQ(N), .DW(W)) bus ();
   spi_req_arbiter #(.NREQ(N), .DW(W), .TIMEOUT(TO)) dut (.clk(clk), .rst(rst), .bus(bus));

   int total = 0, bad = 0, cyc = 0;
   bit m_busy, m_cs_low, m_done_seen;
   int m_gnt, m_ptr, m_age;
   logic [N-1:0] m_ack, m_err;
   logic [W-1:0] m_din;
   bit keep = 0, autoreq = 0, hang = 0, rnd_hang = 0;
   int ms = 0, mcnt = 0;
   logic [W-1:0] cap, lo_din;
   logic [N-1:0] lo_csn, errv;
   int acks[$];

   task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   function automatic int ack_at(int k);
      return (acks.size() > k) ? acks[k] : 99;
   endfunction

   task automatic mreset();
      m_busy = 0; m_cs_low = 0; m_done_seen = 0;
      m_gnt = 0; m_ptr = 0; m_age = 0;
      m_ack = '0; m_err = '0; m_din = '0;
   endtask

   // one clock edge of the transaction-level model, using the inputs held over that edge
   task automatic medge();
      bit fin, blocked;
      blocked = (m_ack | m_err) != 0;
      m_ack = '0; m_err = '0;
      if (!m_busy) begin
         if (bus.req != 0 && bus.spi_cs && !bus.spi_done && !blocked)
            for (int k = 0; k < N; k++)
               if (!m_busy && bus.req[(m_ptr + k) % N]) begin
                  m_gnt = (m_ptr + k) % N;
                  m_busy = 1; m_age = 0; m_cs_low = 0; m_done_seen = 0;
                  m_din = bus.req_data[m_gnt*W +: W];
               end
      end else begin
         fin = 0;
         if (!m_cs_low) m_cs_low = !bus.spi_cs;
         else if (!m_done_seen) m_done_seen = bus.spi_done;
         else fin = !bus.spi_done;
         m_age++;
         if (fin || m_age == TO) begin
            if (fin) m_ack[m_gnt] = 1'b1;
            else m_err[m_gnt] = 1'b1;
            m_busy = 0;
            m_ptr = (m_gnt + 1) % N;
         end
      end
   endtask

   task automatic compare();
      logic [N-1:0] e;
      e = '1;
      if (m_busy) e[m_gnt] = bus.spi_cs;
      chk("busy", bus.busy, m_busy);
      chk("spi_start", bus.spi_start, m_busy && !m_cs_low);
      chk("cs_n", bus.cs_n, e);
      chk("ack", bus.ack, m_ack);
      chk("err", bus.err, m_err);
      chk("spi_din", bus.spi_din, m_din);
      chk("one_pulse", $onehot0(bus.ack | bus.err), 1);
      chk("one_cs", $countones(~bus.cs_n) <= 1, 1);
   endtask

   task automatic master();
      case (ms)
         0: if (bus.spi_start) begin
               if (hang || (rnd_hang && $urandom_range(0, 7) == 0)) ms = 5;
               else begin ms = 1; mcnt = $urandom_range(0, 3); end
            end
         1: if (mcnt == 0) begin
               bus.spi_cs = 1'b0; cap = bus.spi_din; ms = 2; mcnt = $urandom_range(3, 15);
            end else mcnt--;
         2: if (mcnt == 0) begin
               bus.spi_cs = 1'b1; bus.spi_done = 1'b1; ms = 3; mcnt = $urandom_range(0, 4);
            end else mcnt--;
         3: if (mcnt == 0) begin bus.spi_done = 1'b0; ms = 0; end else mcnt--;
         default: if (!bus.spi_start) ms = 0;
      endcase
   endtask

   task automatic clients();
      for (int i = 0; i < N; i++)
         if (!keep && (bus.ack[i] || bus.err[i])) bus.req[i] = 1'b0;
         else if (autoreq && !bus.req[i] && $urandom_range(0, 5) == 0) begin
            bus.req[i] = 1'b1;
            bus.req_data[i*W +: W] = W'($urandom);
         end
   endtask

   task automatic step();
      @(negedge clk);
      cyc++;
      if (rst) mreset(); else medge();
      compare();
      for (int i = 0; i < N; i++) if (bus.ack[i]) acks.push_back(i);
      if (bus.busy && !bus.spi_cs) begin lo_csn = bus.cs_n; lo_din = bus.spi_din; end
      master();
      clients();
   endtask

   task automatic wait_acks(int n, int lim, string nm);
      int k = 0;
      while (acks.size() < n && k < lim) begin step(); k++; end
      chk(nm, acks.size() >= n, 1);
   endtask

   task automatic wait_idle(string nm);
      int k = 0;
      while (bus.busy && k < 500) begin step(); k++; end
      chk(nm, bus.busy, 0);
   endtask

   initial begin
      int k, c0, c1, early;
      int ord[6] = '{0, 1, 3, 0, 1, 3};
      bus.req = '0; bus.req_data = '0; bus.spi_cs = 1'b1; bus.spi_done = 1'b0;
      mreset();
      repeat (3) step();
      chk("rst_cs_n", bus.cs_n, 4'hF);
      chk("rst_busy", bus.busy, 0);
      chk("rst_start", bus.spi_start, 0);
      chk("rst_din", bus.spi_din, 0);
      rst = 1'b0;

      bus.req_data[0 +: W] = 12'hA5C;
      bus.req = 4'b0001;
      wait_acks(1, 200, "single_wait");
      chk("single_ack", ack_at(0), 0);
      chk("single_din", lo_din, 12'hA5C);
      chk("single_csn", lo_csn, 4'b1110);
      repeat (3) step();
      chk("single_idle", bus.busy, 0);
      chk("single_cnt", acks.size(), 1);

      acks.delete();
      rst = 1'b1;
      bus.req_data = {4{W'($urandom)}};
      bus.req = 4'b1011; keep = 1;
      repeat (2) step();
      rst = 1'b0;
      wait_acks(6, 2000, "cont_wait");
      bus.req = '0; keep = 0;
      wait_idle("cont_idle");
      for (int i = 0; i < 6; i++) chk("cont_order", ack_at(i), ord[i]);

      acks.delete();
      hang = 1; bus.req = 4'b0001;
      k = 0; while (!bus.spi_start && k < 50) begin step(); k++; end
      c0 = cyc;
      k = 0; while (!(|bus.err) && k < TO + 50) begin step(); k++; end
      c1 = cyc; errv = bus.err;
      chk("wd_err", errv, 4'b0001);
      chk("wd_time", c1 - c0, TO);
      step();
      chk("wd_start", bus.spi_start, 0);
      hang = 0; bus.req = 4'b0001;
      wait_acks(1, 300, "wd_next_wait");
      chk("wd_next_ack", ack_at(0), 0);

      acks.delete();
      wait_idle("stale_idle0");
      bus.req = 4'b0001;
      wait_acks(1, 200, "stale_first");
      bus.spi_done = 1'b1; ms = 3; mcnt = 49;
      bus.req[2] = 1'b1;
      early = 0; k = 0;
      while (bus.spi_done && k < 100) begin step(); k++; if (bus.busy) early++; end
      chk("stale_nogrant", early, 0);
      wait_acks(2, 200, "stale_wait");
      chk("stale_ack", ack_at(1), 2);
      repeat (5) step();
      chk("stale_cnt", acks.size(), 2);

      acks.delete();
      bus.req_data[W +: W] = 12'h3C7;
      bus.req = 4'b0010;
      k = 0; while (!(bus.busy && !bus.spi_cs) && k < 200) begin step(); k++; end
      rst = 1'b1;
      #1;
      chk("mrst_csn", bus.cs_n, 4'hF);
      chk("mrst_start", bus.spi_start, 0);
      chk("mrst_busy", bus.busy, 0);
      repeat (2) step();
      rst = 1'b0;
      early = 0; k = 0;
      while ((!bus.spi_cs || bus.spi_done) && k < 100) begin step(); k++; if (bus.busy) early++; end
      chk("mrst_nogrant", early, 0);
      wait_acks(1, 300, "mrst_wait");
      chk("mrst_ack", ack_at(0), 1);
      chk("mrst_cap", cap, 12'h3C7);

      acks.delete();
      wait_idle("wdr_idle0");
      bus.req = 4'b0010;
      k = 0; while (!bus.busy && k < 50) begin step(); k++; end
      step();
      bus.req[1] = 1'b0;
      wait_acks(1, 300, "wdr_wait");
      chk("wdr_ack", ack_at(0), 1);
      bus.req = 4'b1111;
      wait_acks(2, 300, "wdr_ptr_wait");
      chk("wdr_ptr", ack_at(1), 2);

      acks.delete();
      autoreq = 1; rnd_hang = 1;
      repeat (4000) step();
      autoreq = 0; rnd_hang = 0;
      bus.req = '0;
      wait_idle("rand_idle");
      chk("rand_acks", acks.size() >= 20, 1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/spi_req_arbiter.md
Name: spi_req_arbiter

Overview:
- Shares one 12-bit SPI master (start/din in; cs/done out) between NREQ requesters.
- Grants requesters round-robin and launches the master with the granted word.
- Routes the master's cs to the granted requester's chip-select line and returns a one-cycle ack (or err on watchdog expiry).
- Sits between client logic and the SPI master, in the same clk domain; the master's sclk is derived from clk.

Parameters:
- NREQ, 4, number of requesters (2..8).
- DW, 12, SPI word width; matches master din.
- TIMEOUT, 1024, clk-cycle watchdog per transaction, counted from launch to done.

Ports:
- clk  input  1  system clock
- rst  input  1  asynchronous reset, active-high
- req  input  NREQ  level request per requester; held until ack/err
- req_data  input  NREQ*DW  word for requester i at bits [i*DW +: DW]
- ack  output  NREQ  one-cycle pulse: transfer of requester i complete
- err  output  NREQ  one-cycle pulse: transfer of requester i timed out
- busy  output  1  high in any state other than IDLE
- cs_n  output  NREQ  per-device chip select, active-low
- spi_start  output  1  to master start
- spi_din  output  DW  to master din
- spi_cs  input  1  from master cs
- spi_done  input  1  from master done

Behaviour:
- Reset values (async, rst=1):
  - state=IDLE; ack, err, spi_start, busy = 0; spi_din=0; cs_n all 1.
  - rr pointer=0; watchdog=0.
- FSM, one transition per clk:
  - IDLE: if any req, pick the first asserted index scanning from ptr upward with wrap; register gnt and spi_din=req_data[gnt]; go to LAUNCH. The grant decision takes 1 cycle.
  - LAUNCH: spi_start=1; hold until spi_cs==0 is sampled, then spi_start=0 and go to XFER. Holding start is required because the master samples start only on sclk edges.
  - XFER: wait for spi_done==1, then go to DRAIN.
  - DRAIN: wait for spi_done==0, which the master produces on its next idle edge. Then pulse ack[gnt] for 1 cycle and set ptr=(gnt+1) mod NREQ. Go to IDLE. Draining prevents a stale done from completing the next transfer.
- Watchdog:
  - Counts clk cycles in LAUNCH, XFER and DRAIN.
  - If it reaches TIMEOUT: spi_start=0, pulse err[gnt], set ptr=gnt+1, return to IDLE.
  - Cleared on entry to LAUNCH.
- cs_n[gnt] = spi_cs (combinational pass-through) while state is not IDLE. All other cs_n bits, and all bits in IDLE, are 1.
- spi_din is stable from LAUNCH entry until the master has captured it, i.e. until IDLE.
- Requests:
  - A req dropped after grant does not abort the transfer; ack still pulses.
  - A req asserted mid-transfer waits for the next IDLE arbitration.
  - Back-to-back: the next grant occurs the cycle after the ack cycle, so one IDLE cycle minimum between transfers.
- Simultaneous requests: round-robin guarantees no requester waits more than NREQ-1 transfers.
- Reset mid-transfer: outputs return to reset values immediately. The master has no reset and completes on its own. After rst, the FSM does not launch while spi_cs==0 or spi_done==1; IDLE additionally requires spi_cs==1 && spi_done==0 before granting.
- At most one bit of ack|err is high in any cycle. ack and err are never simultaneous.

Decomposition:
- Shared package spi_pkg:
  - state encoding IDLE/LAUNCH/XFER/DRAIN (2 bits);
  - SPI_DW=12 constant, shared with the master;
  - TIMEOUT default.
- One sub-module, rr_arbiter (NREQ): inputs req and ptr; outputs gnt index and valid. Purely combinational rotate-priority-encode.
- FSM, watchdog and routing stay in spi_req_arbiter.

Test Plan:
- Single request: req=4'b0001, req_data[0]=12'hA5C, real master attached -> spi_din=12'hA5C; cs_n=4'b1110 while master cs low; exactly one ack=4'b0001 pulse after done falls; busy=0 after.
- Contention: req=4'b1011 held continuously from reset -> grant order 0,1,3,0,1,3; each ack one pulse; cs_n never has two bits low.
- Watchdog: master stubbed so spi_cs stays 1 -> err=4'b0001 pulse exactly TIMEOUT cycles after LAUNCH entry; spi_start=0 afterwards; next request is served normally.
- Stale done: spi_done held 1 for 50 cycles after first transfer while req[2] asserted -> no grant until done=0; req[2] gets exactly one ack, after its own done.
- Reset mid-XFER: rst pulsed while master cs=0 -> cs_n=4'b1111 and spi_start=0 in the same cycle; no grant until master returns cs=1, done=0; following transfer completes with correct data.
- Request withdrawal: req[1] deasserted one cycle after grant -> transfer completes; ack[1] pulses; ptr advances to 2.
